// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared encodings and default widths for regfile_arb
package regfile_arb_pkg;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
endpackage

// File: rtl/regfile_arb_rr_arb2.sv
// rtl/regfile_arb_rr_arb2.sv - two-way round-robin grant with last-served pointer
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic served,
  output logic grant,
  output logic valid
);
  logic last;

  // Pointer resets to m1 so that m0 takes the first tie.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)     last <= M1;
    else if (update) last <= served;
  end

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) grant = (last == M1) ? M0 : M1;
    else              grant = req1 ? M1 : M0;
  end
endmodule

// File: rtl/regfile_arb.sv
// rtl/regfile_arb.sv - two-master arbiter in front of a handshaked register file
module regfile_arb
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              m0_req_,
  input  logic              m0_we_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack_,
  output logic              m0_err_,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req_,
  input  logic              m1_we_,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack_,
  output logic              m1_err_,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  output logic              rf_as_,
  output logic              rf_cs_,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              rf_rdy_
);
  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  logic [1:0] state;
  logic       owner;
  logic [3:0] cnt;
  logic       grant, grant_valid;
  logic       rdy_hit, to_hit, done;

  // Ready wins over timeout when both land in the same cycle.
  assign rdy_hit = (state == ST_ACCESS) && (rf_rdy_ == ENABLE_);
  assign to_hit  = (state == ST_ACCESS) && !rdy_hit && (cnt == TIMEOUT_CNT);
  assign done    = rdy_hit | to_hit;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset_ (reset_),
    .req0   (m0_req_ == ENABLE_),
    .req1   (m1_req_ == ENABLE_),
    .update (done),
    .served (owner),
    .grant  (grant),
    .valid  (grant_valid)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= ST_IDLE;
      owner    <= M0;
      cnt      <= '0;
      m0_ack_  <= DISABLE_;
      m1_ack_  <= DISABLE_;
      m0_err_  <= DISABLE_;
      m1_err_  <= DISABLE_;
      m0_rdata <= '0;
      m1_rdata <= '0;
      rf_addr  <= '0;
      rf_d_in  <= '0;
      rf_we_   <= DISABLE_;
      rf_as_   <= DISABLE_;
      rf_cs_   <= DISABLE_;
    end else begin
      m0_ack_ <= DISABLE_;
      m1_ack_ <= DISABLE_;
      m0_err_ <= DISABLE_;
      m1_err_ <= DISABLE_;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner   <= grant;
            rf_addr <= (grant == M1) ? m1_addr  : m0_addr;
            rf_d_in <= (grant == M1) ? m1_wdata : m0_wdata;
            rf_we_  <= (grant == M1) ? m1_we_   : m0_we_;
            rf_as_  <= ENABLE_;
            rf_cs_  <= ENABLE_;
            cnt     <= '0;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (done) begin
            if (owner == M1) begin
              m1_ack_ <= ENABLE_;
              m1_err_ <= to_hit ? ENABLE_ : DISABLE_;
              if (rdy_hit && rf_we_ == DISABLE_) m1_rdata <= rf_rdata;
            end else begin
              m0_ack_ <= ENABLE_;
              m0_err_ <= to_hit ? ENABLE_ : DISABLE_;
              if (rdy_hit && rf_we_ == DISABLE_) m0_rdata <= rf_rdata;
            end
            rf_we_ <= DISABLE_;
            rf_as_ <= DISABLE_;
            rf_cs_ <= DISABLE_;
            state  <= ST_RELEASE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_arb.sv
// tb/tb_regfile_arb.sv - directed and randomized checks of regfile_arb
module tb_regfile_arb;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset_ = 1'b1;
  logic        m0_req_, m0_we_, m1_req_, m1_we_;
  logic [4:0]  m0_addr, m1_addr, rf_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, rf_d_in, rf_rdata;
  logic        m0_ack_, m0_err_, m1_ack_, m1_err_;
  logic        rf_we_, rf_as_, rf_cs_;
  logic        rf_rdy_ = 1'b1;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:31];
  int fixed_delay = 1;
  logic rand_delay = 1'b0;
  int acc_cycles = 0;
  int cur_delay = 1;

  regfile_arb dut (
    .clk(clk), .reset_(reset_),
    .m0_req_(m0_req_), .m0_we_(m0_we_), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack_(m0_ack_), .m0_err_(m0_err_), .m0_rdata(m0_rdata),
    .m1_req_(m1_req_), .m1_we_(m1_we_), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack_(m1_ack_), .m1_err_(m1_err_), .m1_rdata(m1_rdata),
    .rf_addr(rf_addr), .rf_d_in(rf_d_in), .rf_we_(rf_we_), .rf_as_(rf_as_),
    .rf_cs_(rf_cs_), .rf_rdata(rf_rdata), .rf_rdy_(rf_rdy_)
  );

  always #5 clk = ~clk;

  // Register-file stand-in: ready arrives after a configurable number of select cycles.
  assign rf_rdata = mem[rf_addr];
  always @(negedge clk) begin
    if (rf_as_ == 1'b0) acc_cycles = acc_cycles + 1;
    else begin
      acc_cycles = 0;
      cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
    end
    rf_rdy_ = (rf_as_ == 1'b0 && acc_cycles > cur_delay) ? 1'b0 : 1'b1;
  end
  always @(posedge clk)
    if (rf_as_ == 1'b0 && rf_rdy_ == 1'b0 && rf_we_ == 1'b0) mem[rf_addr] <= rf_d_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    m0_req_ = 1'b1;
    m1_req_ = 1'b1;
    tick(2);
    reset_ = 1'b1;
  endtask

  // Reference model state for the randomized phase
  logic [31:0] model_mem [0:31];
  logic [31:0] model_rdata [0:1];
  logic        act [0:1];
  logic        op_we [0:1];
  logic [4:0]  op_addr [0:1];
  logic [31:0] op_data [0:1];
  int          idle [0:1];
  logic [1:0]  pend_prev;
  int          last_served, exp_owner, w, n_ack, mask;
  logic        prev_as;

  initial begin
    m0_req_ = 1'b1; m0_we_ = 1'b1; m0_addr = '0; m0_wdata = '0;
    m1_req_ = 1'b1; m1_we_ = 1'b1; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0101_0101 * i;
    mem[4] = 32'h1234_5678;

    #1 reset_ = 1'b0;
    #2;
    chk1("rst_m0_ack", m0_ack_, 1'b1);
    chk1("rst_m1_err", m1_err_, 1'b1);
    chk1("rst_rf_as", rf_as_, 1'b1);
    chk1("rst_rf_cs", rf_cs_, 1'b1);
    chk1("rst_rf_we", rf_we_, 1'b1);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    tick(2);
    reset_ = 1'b1;

    // m0 write of 0xDEADBEEF to address 3
    tick(1);
    m0_req_ = 1'b0; m0_we_ = 1'b0; m0_addr = 5'd3; m0_wdata = 32'hDEAD_BEEF;
    tick(1);
    m0_req_ = 1'b1;
    chk1("wr_c1_as", rf_as_, 1'b0);
    chk1("wr_c1_we", rf_we_, 1'b0);
    chk("wr_c1_addr", 32'(rf_addr), 32'd3);
    chk("wr_c1_din", rf_d_in, 32'hDEAD_BEEF);
    tick(1);
    chk1("wr_c2_we", rf_we_, 1'b0);
    chk1("wr_c2_ack", m0_ack_, 1'b1);
    tick(1);
    chk1("wr_c3_ack", m0_ack_, 1'b0);
    chk1("wr_c3_err", m0_err_, 1'b1);
    chk1("wr_c3_m1ack", m1_ack_, 1'b1);
    tick(1);
    chk1("wr_c4_ack", m0_ack_, 1'b1);
    chk1("wr_c4_as", rf_as_, 1'b1);

    // m1 reads address 3 back
    m1_req_ = 1'b0; m1_we_ = 1'b1; m1_addr = 5'd3;
    tick(1);
    m1_req_ = 1'b1;
    tick(2);
    chk1("rd_ack", m1_ack_, 1'b0);
    chk("rd_data", m1_rdata, 32'hDEAD_BEEF);
    chk("rd_other_rdata", m0_rdata, 32'd0);
    tick(1);

    // simultaneous requests right after reset: m0, m1, m0, m1
    do_reset();
    m0_req_ = 1'b0; m0_we_ = 1'b1; m0_addr = 5'd4;
    m1_req_ = 1'b0; m1_we_ = 1'b1; m1_addr = 5'd3;
    for (int k = 0; k < 4; k++) begin
      tick(k == 0 ? 3 : 4);
      chk1("tie_m0_ack", m0_ack_, (k % 2 == 0) ? 1'b0 : 1'b1);
      chk1("tie_m1_ack", m1_ack_, (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    m0_req_ = 1'b1; m1_req_ = 1'b1;
    chk("tie_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("tie_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    tick(2);

    // m0 holds its request for three reads
    m0_req_ = 1'b0; m0_we_ = 1'b1; m0_addr = 5'd3;
    n_ack = 0; mask = 0;
    for (int c = 1; c <= 14; c++) begin
      tick(1);
      if (m0_ack_ == 1'b0) begin n_ack++; mask |= (1 << c); end
      if (c == 9) m0_req_ = 1'b1;
    end
    chk("b2b_count", 32'(n_ack), 32'd3);
    chk("b2b_cycles", 32'(mask), 32'((1 << 3) | (1 << 7) | (1 << 11)));

    // timeout: ready never arrives
    fixed_delay = 1000;
    m0_req_ = 1'b0; m0_addr = 5'd4;
    tick(1);
    m0_req_ = 1'b1;
    tick(TO);
    chk1("to_early_ack", m0_ack_, 1'b1);
    tick(1);
    chk1("to_ack", m0_ack_, 1'b0);
    chk1("to_err", m0_err_, 1'b0);
    chk("to_rdata_kept", m0_rdata, 32'hDEAD_BEEF);
    tick(1);
    chk1("to_release_as", rf_as_, 1'b1);
    chk1("to_err_clear", m0_err_, 1'b1);

    // ready lands exactly when the counter reaches the limit
    fixed_delay = TO;
    m0_req_ = 1'b0; m0_addr = 5'd4;
    tick(1);
    m0_req_ = 1'b1;
    tick(TO + 1);
    chk1("edge_ack", m0_ack_, 1'b0);
    chk1("edge_err", m0_err_, 1'b1);
    chk("edge_rdata", m0_rdata, 32'h1234_5678);
    tick(1);

    // reset in the middle of an access
    fixed_delay = 1;
    m1_req_ = 1'b0; m1_addr = 5'd4;
    tick(1);
    chk1("rsta_as_before", rf_as_, 1'b0);
    #2 reset_ = 1'b0;
    m1_req_ = 1'b1;
    #1;
    chk1("rsta_as", rf_as_, 1'b1);
    chk1("rsta_cs", rf_cs_, 1'b1);
    chk("rsta_rdata", m1_rdata, 32'd0);
    tick(1);
    chk1("rsta_no_ack1", m1_ack_, 1'b1);
    tick(1);
    chk1("rsta_no_ack2", m1_ack_, 1'b1);
    reset_ = 1'b1;
    m1_req_ = 1'b0;
    tick(1);
    m1_req_ = 1'b1;
    tick(2);
    chk1("rsta_fresh_ack", m1_ack_, 1'b0);
    chk("rsta_fresh_rdata", m1_rdata, 32'h1234_5678);
    tick(1);

    // randomized traffic against a transaction-level model
    do_reset();
    rand_delay = 1'b1;
    for (int i = 0; i < 32; i++) model_mem[i] = mem[i];
    model_rdata[0] = 32'd0; model_rdata[1] = 32'd0;
    for (int m = 0; m < 2; m++) begin act[m] = 1'b0; idle[m] = 0; end
    pend_prev = 2'b00; last_served = 1; exp_owner = -1; prev_as = 1'b1; n_ack = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (rf_as_ == 1'b0 && prev_as == 1'b1) begin
        chk1("rnd_grant_pending", pend_prev != 2'b00, 1'b1);
        if (pend_prev == 2'b11) w = (last_served == 1) ? 0 : 1;
        else                    w = pend_prev[1] ? 1 : 0;
        chk("rnd_grant_addr", 32'(rf_addr), 32'(op_addr[w]));
        chk1("rnd_grant_we", rf_we_, op_we[w]);
        exp_owner = w;
        last_served = w;
      end
      prev_as = rf_as_;
      if (m0_ack_ == 1'b0 || m1_ack_ == 1'b0) begin
        n_ack++;
        chk1("rnd_ack_expected", exp_owner >= 0, 1'b1);
        w = (exp_owner >= 0) ? exp_owner : (m1_ack_ == 1'b0 ? 1 : 0);
        chk("rnd_ack_pair", 32'({m0_ack_, m1_ack_}), (w == 1) ? 32'd2 : 32'd1);
        chk("rnd_err_pair", 32'({m0_err_, m1_err_}), 32'd3);
        if (op_we[w] == 1'b0) model_mem[op_addr[w]] = op_data[w];
        else                  model_rdata[w] = model_mem[op_addr[w]];
        chk("rnd_m0_rdata", m0_rdata, model_rdata[0]);
        chk("rnd_m1_rdata", m1_rdata, model_rdata[1]);
        act[w] = 1'b0;
        idle[w] = $urandom_range(0, 3);
        exp_owner = -1;
      end
      for (int m = 0; m < 2; m++) begin
        if (!act[m]) begin
          if (idle[m] > 0) idle[m]--;
          else begin
            act[m] = 1'b1;
            op_we[m] = $urandom_range(0, 1) == 0;
            op_addr[m] = 5'($urandom_range(0, 31));
            op_data[m] = $urandom;
          end
        end
      end
      m0_req_ = !act[0]; m0_we_ = op_we[0]; m0_addr = op_addr[0]; m0_wdata = op_data[0];
      m1_req_ = !act[1]; m1_we_ = op_we[1]; m1_addr = op_addr[1]; m1_wdata = op_data[1];
      pend_prev = {act[1], act[0]};
      tick(1);
    end
    chk1("rnd_progress", n_ack > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Interface
REQ-001 Parameter ADDR_W, default 5: register-file address width (32 entries).
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles spent in ACCESS waiting for rdy_.
REQ-004 clk  in  1  clock; all state changes on posedge.
REQ-005 reset_  in  1  asynchronous, active-low reset.
REQ-006 m0_req_ / m1_req_  in  1  per-master access request, active-low, level.
REQ-007 m0_we_ / m1_we_  in  1  per-master write enable, active-low; high = read.
REQ-008 m0_addr / m1_addr  in  ADDR_W  per-master register address.
REQ-009 m0_wdata / m1_wdata  in  DATA_W  per-master write data.
REQ-010 m0_ack_ / m1_ack_  out  1  one-cycle completion strobe, active-low.
REQ-011 m0_err_ / m1_err_  out  1  one-cycle timeout strobe, active-low, coincident with ack_.
REQ-012 m0_rdata / m1_rdata  out  DATA_W  read data, valid from ack_ onward, held until the next read completes for that master.
REQ-013 rf_addr, rf_d_in, rf_we_, rf_as_, rf_cs_  out  ADDR_W / DATA_W / 1 / 1 / 1  register-file access port.
REQ-014 rf_rdata  in  DATA_W  register-file read data.
REQ-015 rf_rdy_  in  1  register-file ready, active-low.

Function
REQ-016 FSM states: IDLE, ACCESS, RELEASE; reset state IDLE.
REQ-017 IDLE: when any req_ is low, register the winner's addr/we_/wdata onto the rf_* outputs and go to ACCESS; otherwise stay.
REQ-018 Arbitration: round-robin with a 1-bit last-served pointer; a sole requester always wins; on simultaneous requests, the master not last served wins; the pointer resets to favour m0.
REQ-019 ACCESS: rf_as_ and rf_cs_ low; rf_we_ equals the latched we_; rf_addr and rf_d_in are held stable for the whole state.
REQ-020 In ACCESS, when rf_rdy_ is sampled low: capture rf_rdata into the winner's rdata (reads only), pulse the winner's ack_ low for the next cycle, update the pointer, and go to RELEASE.
REQ-021 Nominal latency: req_ sampled in cycle 0, ACCESS in cycles 1-2, ack_ low in cycle 3.
REQ-022 RELEASE: exactly one cycle with rf_as_, rf_cs_ and rf_we_ high, then IDLE; a request still low in IDLE starts a new transaction.
REQ-023 Minimum spacing between successive grants is 4 cycles; the losing master's req_ stays pending and is never dropped.
REQ-024 Timeout: a 4-bit counter clears on ACCESS entry and increments each ACCESS cycle; at count = TIMEOUT with rf_rdy_ still high, pulse the winner's ack_ and err_ together, leave its rdata unchanged, and go to RELEASE.
REQ-025 rf_rdy_ low in the same cycle the counter reaches TIMEOUT counts as success (no err_).
REQ-026 A master's req_ that goes high mid-ACCESS does not abort the transfer; ack_ is still issued.
REQ-027 rf_rdy_ is ignored outside ACCESS.
REQ-028 Only the granted master's ack_, err_ and rdata ever change.

Reset
REQ-029 Asserting reset_ immediately forces: state IDLE, pointer = m1 (so m0 wins the first tie), counter 0, all ack_/err_/rf_we_/rf_as_/rf_cs_ high, rf_addr/rf_d_in/m0_rdata/m1_rdata zero.
REQ-030 Reset during ACCESS abandons the transfer with no ack_; deassertion takes effect on the next posedge.

Structure
REQ-031 A shared package holds the FSM state encoding, ENABLE_/DISABLE_ levels and the default widths.
REQ-032 One sub-module, rr_arb2 (2-way round-robin grant with pointer), is instantiated; datapath muxing and the FSM stay in regfile_arb.

Verification
REQ-033 Write: m0 writes addr 3 = 0xDEADBEEF -> rf_we_ low in cycles 1-2, m0_ack_ low in cycle 3; a later m1 read of addr 3 returns 0xDEADBEEF.
REQ-034 Tie: both req_ low in the first cycle after reset -> m0 served first, then m1; with both still held, the order alternates m0, m1, m0.
REQ-035 Back-to-back: m0 holds req_ for 3 reads -> grants 4 cycles apart, 3 ack_ pulses.
REQ-036 Timeout: rf_rdy_ forced high during a read -> ack_ and err_ low together in cycle TIMEOUT+2, rdata unchanged, FSM back in IDLE.
REQ-037 Reset in ACCESS: reset_ pulsed low -> no ack_, rf_as_/rf_cs_ high immediately, and a fresh request is served normally after release.
